// File: rtl/cpu_defs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : cpu_defs                                                   |
// | Shared fetch-stage definitions: PC redirect codes, reset PC, nop.    |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
package cpu_defs;

    typedef enum logic [1:0] {
        PCC_SEQ = 2'd0,
        PCC_BR  = 2'd1,
        PCC_JR  = 2'd2,
        PCC_J   = 2'd3
    } pcc_e;

    localparam logic [31:0] c_RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] c_NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] c_PC_STEP          = 32'd4;

endpackage

`default_nettype wire

// File: rtl/pc_fetch_unit_npc_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : npc_sel                                                    |
// | Combinational next-PC mux with jr/jalr target misalign detect.       |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module npc_sel
    import cpu_defs::*;
(
    input  logic [1:0]  i_pcc,
    input  logic [31:0] i_pcf,
    input  logic [31:0] i_pc4d,
    input  logic [25:0] i_instrd,
    input  logic [31:0] i_rsd,
    output logic [31:0] o_npc,
    output logic        o_misalign
);

    pcc_e w_pcc;

    assign w_pcc = pcc_e'(i_pcc);

    always_comb begin
        o_npc = i_pcf + c_PC_STEP;
        case (w_pcc)
            PCC_BR:  o_npc = i_pc4d + {{14{i_instrd[15]}}, i_instrd[15:0], 2'b00};
            // Low bits are forced to zero so PCF can never go unaligned.
            PCC_JR:  o_npc = {i_rsd[31:2], 2'b00};
            PCC_J:   o_npc = {i_pc4d[31:28], i_instrd[25:0], 2'b00};
            default: o_npc = i_pcf + c_PC_STEP;
        endcase
    end

    assign o_misalign = (w_pcc == PCC_JR) && (i_rsd[1:0] != 2'b00);

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pc_fetch_unit                                              |
// | Fetch stage: owns PCF, the IF/ID register and sticky AlignErr.       |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module pc_fetch_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC_DEFAULT
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic [1:0]  PCControl,
    input  logic [31:0] RsD,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PC4D,
    output logic        ValidD,
    output logic        AlignErr
);

    logic [31:0] r_pcf;
    logic [31:0] r_instrd;
    logic [31:0] r_pcd;
    logic [31:0] r_pc4d;
    logic        r_validd;
    logic        r_align_err;

    logic [31:0] w_npc;
    logic        w_misalign;

    npc_sel u_npc_sel (
        .i_pcc      (PCControl),
        .i_pcf      (r_pcf),
        .i_pc4d     (r_pc4d),
        .i_instrd   (r_instrd[25:0]),
        .i_rsd      (RsD),
        .o_npc      (w_npc),
        .o_misalign (w_misalign)
    );

    // A stalled cycle drops the redirect; D re-presents it once Stall clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcf       <= RESET_PC;
            r_instrd    <= c_NOP_INSTR;
            r_pcd       <= 32'h0;
            r_pc4d      <= 32'h0;
            r_validd    <= 1'b0;
            r_align_err <= 1'b0;
        end else if (!Stall) begin
            r_pcf    <= w_npc;
            r_instrd <= InstrF;
            r_pcd    <= r_pcf;
            r_pc4d   <= r_pcf + c_PC_STEP;
            r_validd <= 1'b1;
            if (w_misalign) begin
                r_align_err <= 1'b1;
            end
        end
    end

    assign PCF      = r_pcf;
    assign InstrD   = r_instrd;
    assign PCD      = r_pcd;
    assign PC4D     = r_pc4d;
    assign ValidD   = r_validd;
    assign AlignErr = r_align_err;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_pc_fetch_unit                                           |
// | Directed-vector scoreboard bench for pc_fetch_unit.                  |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic        Stall;
    logic [1:0]  PCControl;
    logic [31:0] RsD;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PC4D;
    logic        ValidD;
    logic        AlignErr;

    pc_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk       (clk),
        .reset     (reset),
        .Stall     (Stall),
        .PCControl (PCControl),
        .RsD       (RsD),
        .InstrF    (InstrF),
        .PCF       (PCF),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PC4D      (PC4D),
        .ValidD    (ValidD),
        .AlignErr  (AlignErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic [1:0]  pcc;
        logic [31:0] rsd;
        logic [31:0] instrf;
        logic [31:0] e_pcf;
        logic [31:0] e_instrd;
        logic [31:0] e_pcd;
        logic [31:0] e_pc4d;
        logic        e_valid;
        logic        e_aerr;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] pcf;
        logic [31:0] instrd;
        logic [31:0] pcd;
        logic [31:0] pc4d;
        logic        valid;
        logic        aerr;
    } exp_t;

    localparam logic [31:0] c_BEQ_M2 = 32'h1000_FFFE;
    localparam logic [31:0] c_BEQ_P4 = 32'h1000_0004;
    localparam logic [31:0] c_DS     = 32'h2400_0001;
    localparam logic [31:0] c_JMP    = 32'h0800_0C10;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic add(input logic r, input logic s, input logic [1:0] p,
                       input logic [31:0] rs, input logic [31:0] inf,
                       input logic [31:0] epcf, input logic [31:0] eid,
                       input logic [31:0] epcd, input logic [31:0] ep4,
                       input logic ev, input logic ea);
        vec_t v;
        v.rst = r; v.stall = s; v.pcc = p; v.rsd = rs; v.instrf = inf;
        v.e_pcf = epcf; v.e_instrd = eid; v.e_pcd = epcd; v.e_pc4d = ep4;
        v.e_valid = ev; v.e_aerr = ea;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Monitor: the DUT presents a new IF/ID state after every posedge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("PCF",      e.idx, PCF,            e.pcf);
                chk("InstrD",   e.idx, InstrD,         e.instrd);
                chk("PCD",      e.idx, PCD,            e.pcd);
                chk("PC4D",     e.idx, PC4D,           e.pc4d);
                chk("ValidD",   e.idx, {31'd0, ValidD},   {31'd0, e.valid});
                chk("AlignErr", e.idx, {31'd0, AlignErr}, {31'd0, e.aerr});
            end
        end
    end

    initial begin
        exp_t e;
        int   guard;
        // rst stall pcc RsD InstrF | PCF InstrD PCD PC4D Valid AErr
        add(1,0,0,0,0,                32'h3000,0,0,0,0,0);                       // reset
        add(0,0,0,0,0,                32'h3004,0,32'h3000,32'h3004,1,0);
        add(0,0,0,0,0,                32'h3008,0,32'h3004,32'h3008,1,0);
        add(0,0,0,0,0,                32'h300C,0,32'h3008,32'h300C,1,0);
        add(0,0,0,0,c_BEQ_M2,         32'h3010,c_BEQ_M2,32'h300C,32'h3010,1,0);
        add(0,0,1,0,c_DS,             32'h3008,c_DS,32'h3010,32'h3014,1,0);      // beq back
        add(0,0,0,0,0,                32'h300C,0,32'h3008,32'h300C,1,0);
        add(0,0,0,0,c_BEQ_M2,         32'h3010,c_BEQ_M2,32'h300C,32'h3010,1,0);
        add(0,1,1,0,c_DS,             32'h3010,c_BEQ_M2,32'h300C,32'h3010,1,0);  // stall x3
        add(0,1,1,0,c_DS,             32'h3010,c_BEQ_M2,32'h300C,32'h3010,1,0);
        add(0,1,1,0,c_DS,             32'h3010,c_BEQ_M2,32'h300C,32'h3010,1,0);
        add(0,0,1,0,c_DS,             32'h3008,c_DS,32'h3010,32'h3014,1,0);      // branch applies
        add(0,0,2,32'h3102,0,         32'h3100,0,32'h3008,32'h300C,1,1);         // jr misaligned
        add(0,0,0,0,0,                32'h3104,0,32'h3100,32'h3104,1,1);         // sticky
        add(1,1,0,0,0,                32'h3000,0,0,0,0,0);                       // reset under stall
        add(0,0,0,0,c_JMP,            32'h3004,c_JMP,32'h3000,32'h3004,1,0);
        add(0,0,3,0,0,                32'h3040,0,32'h3004,32'h3008,1,0);         // j
        add(0,0,0,0,0,                32'h3044,0,32'h3040,32'h3044,1,0);
        add(0,1,2,32'h3102,0,         32'h3044,0,32'h3040,32'h3044,1,0);         // stalled jr: no flag
        add(0,0,0,0,0,                32'h3048,0,32'h3044,32'h3048,1,0);
        add(0,0,2,32'hFFFF_FFF8,0,    32'hFFFF_FFF8,0,32'h3048,32'h304C,1,0);    // aligned jr
        add(0,0,0,0,c_BEQ_P4,         32'hFFFF_FFFC,c_BEQ_P4,32'hFFFF_FFF8,32'hFFFF_FFFC,1,0);
        add(0,0,1,0,0,                32'h0000_000C,0,32'hFFFF_FFFC,32'h0000_0000,1,0); // wrap
        add(1,1,0,0,0,                32'h3000,0,0,0,0,0);                       // mid-run reset
        add(0,0,0,0,0,                32'h3004,0,32'h3000,32'h3004,1,0);

        reset = 1'b1; Stall = 1'b0; PCControl = 2'd0; RsD = 32'h0; InstrF = 32'h0;
        for (int i = 0; i < vecs.size(); i++) begin
            reset     = vecs[i].rst;
            Stall     = vecs[i].stall;
            PCControl = vecs[i].pcc;
            RsD       = vecs[i].rsd;
            InstrF    = vecs[i].instrf;
            @(posedge clk);
            e.idx = i; e.pcf = vecs[i].e_pcf; e.instrd = vecs[i].e_instrd;
            e.pcd = vecs[i].e_pcd; e.pc4d = vecs[i].e_pc4d;
            e.valid = vecs[i].e_valid; e.aerr = vecs[i].e_aerr;
            sb.push_back(e);
            @(negedge clk);
        end

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
